// File: rtl/dense_seq_mac.sv
// Time-multiplexed dense layer: LANES shared multipliers iterate over neurons and
// weight chunks streamed from a synchronous RAM. Optional ReLU via DENSE_SEQ_RELU_EN.
module dense_seq_mac #(
  parameter int HIDDEN_SZ = 64,
  parameter int OUTPUT_SZ = 16,
  parameter int LANES     = 4,
  parameter int QN        = 6,
  parameter int QM        = 11,
  parameter int BITWIDTH  = QN + QM + 1,
  parameter int CH        = HIDDEN_SZ / LANES,
  parameter int W_ADDR_W  = (OUTPUT_SZ * CH > 1) ? $clog2(OUTPUT_SZ * CH) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dataReady,
  input  logic [HIDDEN_SZ*BITWIDTH-1:0] inputVec,
  input  logic [OUTPUT_SZ*BITWIDTH-1:0] W_DENSE_B,
  output logic                          w_rd_en,
  output logic [W_ADDR_W-1:0]           w_rd_addr,
  input  logic [LANES*BITWIDTH-1:0]     w_rd_data,
  output logic                          busy,
  output logic [OUTPUT_SZ*BITWIDTH-1:0] outputVec,
  output logic                          dataReady_out
);

  localparam int PW = 2 * BITWIDTH;
  localparam int AW = 2 * BITWIDTH + $clog2(HIDDEN_SZ) + 1;
  localparam int KW = (CH > 1) ? $clog2(CH) : 1;
  localparam int NW = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;

  localparam logic [KW-1:0]        K_LAST  = KW'(CH - 1);
  localparam logic [NW-1:0]        N_LAST  = NW'(OUTPUT_SZ - 1);
  localparam logic signed [AW:0]   HALF    = (AW+1)'(2 ** (QM - 1));
  localparam logic signed [AW:0]   SAT_MAX = (AW+1)'(2 ** (BITWIDTH - 1) - 1);
  localparam logic signed [AW:0]   SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN,
    S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [NW-1:0]                   n_q, n_d;
  logic [KW-1:0]                   k_q, k_d;
  logic [W_ADDR_W-1:0]             addr_q, addr_d;
  logic                            rd_en_q, rd_en_d;
  logic                            busy_q, busy_d;
  logic                            pulse_q, pulse_d;
  logic                            pend_vld_q, pend_vld_d;
  logic                            pend_first_q, pend_first_d;
  logic [KW-1:0]                   pend_k_q, pend_k_d;
  logic signed [AW-1:0]            acc_q, acc_d;
  logic [OUTPUT_SZ*BITWIDTH-1:0]   res_q, res_d;
  logic [OUTPUT_SZ*BITWIDTH-1:0]   out_q, out_d;
  logic [HIDDEN_SZ*BITWIDTH-1:0]   x_q;
  logic                            accept;

  logic signed [BITWIDTH-1:0]      x_lane, w_lane;
  logic signed [PW-1:0]            prod;
  logic signed [AW-1:0]            prod_ext, chunk_sum;

  logic signed [BITWIDTH-1:0]      bias_n;
  logic signed [AW:0]              acc_ext, bias_ext, rnd_sum, shifted;
  logic [BITWIDTH-1:0]             r_out;

  // Sum of LANES products for the chunk whose weights arrive this cycle.
  always_comb begin
    chunk_sum = '0;
    x_lane    = '0;
    w_lane    = '0;
    prod      = '0;
    prod_ext  = '0;
    for (int j = 0; j < LANES; j++) begin
      x_lane    = x_q[(int'(pend_k_q) * LANES + j) * BITWIDTH +: BITWIDTH];
      w_lane    = w_rd_data[j * BITWIDTH +: BITWIDTH];
      prod      = PW'(x_lane) * PW'(w_lane);
      prod_ext  = AW'(prod);
      chunk_sum = chunk_sum + prod_ext;
    end
  end

  // Bias add, round-half-up, arithmetic shift and saturation for neuron n_q.
  always_comb begin
    bias_n   = W_DENSE_B[int'(n_q) * BITWIDTH +: BITWIDTH];
    acc_ext  = (AW+1)'(acc_q);
    bias_ext = (AW+1)'(bias_n);
    rnd_sum  = acc_ext + (bias_ext <<< QM) + HALF;
    shifted  = rnd_sum >>> QM;
    if (shifted > SAT_MAX) begin
      r_out = SAT_MAX[BITWIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      r_out = SAT_MIN[BITWIDTH-1:0];
    end else begin
      r_out = shifted[BITWIDTH-1:0];
    end
`ifdef DENSE_SEQ_RELU_EN
    if (r_out[BITWIDTH-1]) begin
      r_out = '0;
    end
`endif
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    addr_d  = addr_q;
    res_d   = res_q;
    out_d   = out_q;
    acc_d   = acc_q;
    accept  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dataReady) begin
          accept  = 1'b1;
          n_d     = '0;
          k_d     = '0;
          addr_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        addr_d = addr_q + W_ADDR_W'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: state_d = S_FIN;
      S_FIN: begin
        res_d[int'(n_q) * BITWIDTH +: BITWIDTH] = r_out;
        if (n_q == N_LAST) begin
          out_d   = res_d;
          state_d = S_DONE;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Weights requested in a RUN cycle are consumed one cycle later.
    pend_vld_d   = (state_q == S_RUN);
    pend_first_d = (k_q == '0);
    pend_k_d     = k_q;
    if (pend_vld_q) begin
      acc_d = (pend_first_q ? AW'(0) : acc_q) + chunk_sum;
    end

    rd_en_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    pulse_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      k_q          <= '0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      pulse_q      <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_first_q <= 1'b0;
      pend_k_q     <= '0;
      acc_q        <= '0;
      res_q        <= '0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      pulse_q      <= pulse_d;
      pend_vld_q   <= pend_vld_d;
      pend_first_q <= pend_first_d;
      pend_k_q     <= pend_k_d;
      acc_q        <= acc_d;
      res_q        <= res_d;
      out_q        <= out_d;
    end
  end

  // NOTE: the latched input vector is pure storage, overwritten on every accept,
  // so it carries no reset.
  always_ff @(posedge clock) begin
    if (accept && !reset) begin
      x_q <= inputVec;
    end
  end

  assign w_rd_en       = rd_en_q;
  assign w_rd_addr     = addr_q;
  assign busy          = busy_q;
  assign outputVec     = out_q;
  assign dataReady_out = pulse_q;

endmodule
